// File: rtl/xt_bus_pkg.sv
// Shared XT bus definitions: LB bridge state encoding, default timeout/error data
// and the helper that extracts a peripheral index from an LB address.
package xt_bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RESP = 2'd3
   } lb_bridge_state_e;

   localparam int          LB_TIMEOUT_DEFAULT = 15;
   localparam logic [31:0] LB_ERR_RDATA       = 32'hDEAD_BEEF;

   // Peripheral index lives in the top sel_w bits of an lb_aw-wide address.
   function automatic logic [31:0] lb_slave_index(input logic [31:0] addr,
                                                  input int          lb_aw,
                                                  input int          sel_w);
      logic [31:0] mask;
      mask = (32'd1 << sel_w) - 32'd1;
      return (addr >> (lb_aw - sel_w)) & mask;
   endfunction

endpackage

// File: rtl/xt_lb_watchdog.sv
// Per-access wait counter; flags expiry when the limit is reached and ready is
// still low in that same cycle, so a last-moment ready is treated as success.
module xt_lb_watchdog
   import xt_bus_pkg::*;
#(
   parameter int TIMEOUT = LB_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   input  logic ready,
   output logic expire
);

   logic [7:0] count_q;
   logic [7:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !ready) begin
         count_d = count_q + 8'd1;
      end
   end

   assign expire = enable && !ready && (count_q == 8'(TIMEOUT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/xt_lb_bridge.sv
// XT_HB slave to shared XT_LB segment bridge: write-before-read ordering,
// per-slave wait states, read-data mux and a timeout watchdog with sticky error.
module xt_lb_bridge
   import xt_bus_pkg::*;
#(
   parameter int          HB_AW      = 14,
   parameter int          LB_AW      = 8,
   parameter int          NUM_SLAVES = 4,
   parameter int          SEL_W      = $clog2(NUM_SLAVES),
   parameter int          TIMEOUT    = LB_TIMEOUT_DEFAULT,
   parameter logic [31:0] ERR_RDATA  = LB_ERR_RDATA
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     hb_ren,
   input  logic                     hb_wen,
   input  logic [HB_AW-1:0]         hb_raddr,
   input  logic [HB_AW-1:0]         hb_waddr,
   input  logic [31:0]              hb_wdata,
   input  logic [1:0]               hb_write_width,
   output logic                     hb_ready,
   output logic [31:0]              hb_rdata,
   output logic                     hb_rvalid,
   output logic                     lb_ren,
   output logic                     lb_wen,
   output logic [LB_AW-1:0]         lb_addr,
   output logic [31:0]              lb_wdata,
   output logic [1:0]               lb_write_width,
   input  logic [NUM_SLAVES*32-1:0] slv_rdata,
   input  logic [NUM_SLAVES-1:0]    slv_ready,
   input  logic                     err_clr,
   output logic                     err,
   output logic [LB_AW-1:0]         err_addr
);

   lb_bridge_state_e state_q, state_d;
   logic [LB_AW-1:0] raddr_q, raddr_d;
   logic             rd_pend_q, rd_pend_d;
   logic [LB_AW-1:0] lb_addr_q, lb_addr_d;
   logic [31:0]      lb_wdata_q, lb_wdata_d;
   logic [1:0]       lb_width_q, lb_width_d;
   logic             lb_ren_q, lb_ren_d;
   logic             lb_wen_q, lb_wen_d;
   logic             hb_ready_q, hb_ready_d;
   logic [31:0]      hb_rdata_q, hb_rdata_d;
   logic             hb_rvalid_q, hb_rvalid_d;
   logic             err_q, err_d;
   logic [LB_AW-1:0] err_addr_q, err_addr_d;

   logic [SEL_W-1:0] sel_idx;
   logic             sel_ready;
   logic [31:0]      sel_rdata;
   logic             in_access;
   logic             access_done;
   logic             expire;

   // lb_addr_q already holds the address of whichever access is on the bus.
   assign sel_idx     = SEL_W'(lb_slave_index(32'(lb_addr_q), LB_AW, SEL_W));
   assign sel_ready   = slv_ready[sel_idx];
   assign sel_rdata   = slv_rdata[32*int'(sel_idx) +: 32];
   assign in_access   = (state_q == WR) || (state_q == RD);
   assign access_done = in_access && (sel_ready || expire);

   xt_lb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (!in_access || access_done),
      .enable (in_access),
      .ready  (sel_ready),
      .expire (expire)
   );

   generate
      if (HB_AW > LB_AW) begin : g_hb_upper
         logic unused_hb_upper;
         assign unused_hb_upper = ^{hb_raddr[HB_AW-1:LB_AW], hb_waddr[HB_AW-1:LB_AW]};
      end
   endgenerate

   always_comb begin
      // NOTE: every _d starts from its current value so no branch below can infer a latch.
      state_d     = state_q;
      raddr_d     = raddr_q;
      rd_pend_d   = rd_pend_q;
      lb_addr_d   = lb_addr_q;
      lb_wdata_d  = lb_wdata_q;
      lb_width_d  = lb_width_q;
      lb_ren_d    = lb_ren_q;
      lb_wen_d    = lb_wen_q;
      hb_ready_d  = hb_ready_q;
      hb_rdata_d  = hb_rdata_q;
      hb_rvalid_d = 1'b0;
      err_d       = err_q;
      err_addr_d  = err_addr_q;

      case (state_q)
         IDLE: begin
            if (hb_wen || hb_ren) begin
               raddr_d    = hb_raddr[LB_AW-1:0];
               lb_wdata_d = hb_wdata;
               lb_width_d = hb_write_width;
               rd_pend_d  = hb_wen && hb_ren;
               hb_ready_d = 1'b0;
               if (hb_wen) begin
                  state_d   = WR;
                  lb_wen_d  = 1'b1;
                  lb_addr_d = hb_waddr[LB_AW-1:0];
               end else begin
                  state_d   = RD;
                  lb_ren_d  = 1'b1;
                  lb_addr_d = hb_raddr[LB_AW-1:0];
               end
            end
         end
         WR: begin
            if (access_done) begin
               lb_wen_d = 1'b0;
               if (rd_pend_q) begin
                  state_d   = RD;
                  rd_pend_d = 1'b0;
                  lb_ren_d  = 1'b1;
                  lb_addr_d = raddr_q;
               end else begin
                  state_d    = IDLE;
                  hb_ready_d = 1'b1;
               end
            end
         end
         RD: begin
            if (access_done) begin
               lb_ren_d   = 1'b0;
               hb_rdata_d = sel_ready ? sel_rdata : ERR_RDATA;
               state_d    = RESP;
            end
         end
         RESP: begin
            hb_rvalid_d = 1'b1;
            hb_ready_d  = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A timeout in the same cycle as err_clr wins and reloads the address.
      if (expire) begin
         err_d = 1'b1;
         if (!err_q || err_clr) begin
            err_addr_d = lb_addr_q;
         end
      end else if (err_clr) begin
         err_d      = 1'b0;
         err_addr_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         raddr_q     <= '0;
         rd_pend_q   <= 1'b0;
         lb_addr_q   <= '0;
         lb_wdata_q  <= '0;
         lb_width_q  <= '0;
         lb_ren_q    <= 1'b0;
         lb_wen_q    <= 1'b0;
         hb_ready_q  <= 1'b1;
         hb_rdata_q  <= '0;
         hb_rvalid_q <= 1'b0;
         err_q       <= 1'b0;
         err_addr_q  <= '0;
      end else begin
         state_q     <= state_d;
         raddr_q     <= raddr_d;
         rd_pend_q   <= rd_pend_d;
         lb_addr_q   <= lb_addr_d;
         lb_wdata_q  <= lb_wdata_d;
         lb_width_q  <= lb_width_d;
         lb_ren_q    <= lb_ren_d;
         lb_wen_q    <= lb_wen_d;
         hb_ready_q  <= hb_ready_d;
         hb_rdata_q  <= hb_rdata_d;
         hb_rvalid_q <= hb_rvalid_d;
         err_q       <= err_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign hb_ready       = hb_ready_q;
   assign hb_rdata       = hb_rdata_q;
   assign hb_rvalid      = hb_rvalid_q;
   assign lb_ren         = lb_ren_q;
   assign lb_wen         = lb_wen_q;
   assign lb_addr        = lb_addr_q;
   assign lb_wdata       = lb_wdata_q;
   assign lb_write_width = lb_width_q;
   assign err            = err_q;
   assign err_addr       = err_addr_q;

endmodule

// File: tb/tb_xt_lb_bridge.sv
// Directed bench for xt_lb_bridge: a table of HB transactions against four modelled
// peripherals (slave 1 has 3 wait states, slave 3 never answers) plus corner sequences.
module tb_xt_lb_bridge;

   logic         clk = 1'b0;
   logic         rst;
   logic         hb_ren, hb_wen;
   logic [13:0]  hb_raddr, hb_waddr;
   logic [31:0]  hb_wdata;
   logic [1:0]   hb_write_width;
   logic         hb_ready, hb_rvalid;
   logic [31:0]  hb_rdata;
   logic         lb_ren, lb_wen;
   logic [7:0]   lb_addr;
   logic [31:0]  lb_wdata;
   logic [1:0]   lb_write_width;
   logic [127:0] slv_rdata;
   logic [3:0]   slv_ready;
   logic         err_clr;
   logic         err;
   logic [7:0]   err_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   xt_lb_bridge dut (
      .clk            (clk),
      .rst            (rst),
      .hb_ren         (hb_ren),
      .hb_wen         (hb_wen),
      .hb_raddr       (hb_raddr),
      .hb_waddr       (hb_waddr),
      .hb_wdata       (hb_wdata),
      .hb_write_width (hb_write_width),
      .hb_ready       (hb_ready),
      .hb_rdata       (hb_rdata),
      .hb_rvalid      (hb_rvalid),
      .lb_ren         (lb_ren),
      .lb_wen         (lb_wen),
      .lb_addr        (lb_addr),
      .lb_wdata       (lb_wdata),
      .lb_write_width (lb_write_width),
      .slv_rdata      (slv_rdata),
      .slv_ready      (slv_ready),
      .err_clr        (err_clr),
      .err            (err),
      .err_addr       (err_addr)
   );

   // Peripheral model: each slave qualifies the broadcast by lb_addr[7:6] and
   // answers after its configured number of wait cycles (-1 = never).
   int wait_cfg [4] = '{0, 3, 0, -1};
   int wcnt = 0;

   assign slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h0000_1111};

   always_comb begin
      slv_ready = '0;
      for (int i = 0; i < 4; i++) begin
         if ((lb_ren || lb_wen) && (lb_addr[7:6] == 2'(i)) &&
             (wait_cfg[i] >= 0) && (wcnt >= wait_cfg[i]))
            slv_ready[i] = 1'b1;
      end
   end

   always @(posedge clk) begin
      if ((lb_ren || lb_wen) && (slv_ready == 4'b0)) wcnt <= wcnt + 1;
      else                                           wcnt <= 0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic        ren;
      logic        wen;
      logic [13:0] raddr;
      logic [13:0] waddr;
      logic [31:0] wdata;
      logic [1:0]  wwidth;
      int          lat;       // cycles from request cycle to hb_ready back high
      int          wen_cyc;
      int          ren_cyc;
      logic [31:0] rdata;
      logic        err;
      logic [7:0]  err_addr;
   } vec_t;

   vec_t        vecs [8];
   logic [31:0] rdata_hold = '0;

   task automatic run_vec(input vec_t v);
      int          cyc = 0, wc = 0, rc = 0, rv = 0, bad = 0;
      logic [31:0] rd = '0;
      @(negedge clk);
      hb_ren = v.ren; hb_wen = v.wen; hb_raddr = v.raddr; hb_waddr = v.waddr;
      hb_wdata = v.wdata; hb_write_width = v.wwidth;
      do begin
         @(negedge clk);
         cyc++;
         hb_ren = 1'b0; hb_wen = 1'b0;
         if (lb_wen) begin
            wc++;
            if (lb_addr !== v.waddr[7:0] || lb_wdata !== v.wdata || lb_write_width !== v.wwidth)
               bad++;
         end
         if (lb_ren) begin
            rc++;
            if (lb_addr !== v.raddr[7:0]) bad++;
         end
         if (lb_ren && lb_wen) bad++;
         if (hb_rvalid) begin
            rv++;
            rd = hb_rdata;
         end
      end while (hb_ready !== 1'b1 && cyc < 64);
      check({v.name, " latency"},  cyc, v.lat);
      check({v.name, " wen_cyc"},  wc,  v.wen_cyc);
      check({v.name, " ren_cyc"},  rc,  v.ren_cyc);
      check({v.name, " lb_bad"},   bad, 0);
      check({v.name, " rvalids"},  rv,  v.ren ? 1 : 0);
      if (v.ren) begin
         check({v.name, " rdata"}, rd, v.rdata);
         rdata_hold = v.rdata;
      end
      check({v.name, " err"},      err,      v.err);
      check({v.name, " err_addr"}, err_addr, v.err_addr);
      @(negedge clk);
      check({v.name, " rvalid_gone"}, hb_rvalid, 1'b0);
      check({v.name, " rdata_hold"},  hb_rdata,  rdata_hold);
   endtask

   initial begin
      int rv_cnt;
      rst = 1'b1; hb_ren = 1'b0; hb_wen = 1'b0; hb_raddr = '0; hb_waddr = '0;
      hb_wdata = '0; hb_write_width = '0; err_clr = 1'b0;

      repeat (2) @(negedge clk);
      check("rst hb_ready",  hb_ready,  1'b1);
      check("rst hb_rvalid", hb_rvalid, 1'b0);
      check("rst lb_ren",    lb_ren,    1'b0);
      check("rst lb_wen",    lb_wen,    1'b0);
      check("rst err",       err,       1'b0);
      rst = 1'b0;

      //           name           ren   wen   raddr     waddr     wdata          ww     lat wc  rc  rdata          err   err_addr
      vecs[0] = '{"wr_s2",        1'b0, 1'b1, 14'h0000, 14'h30A5, 32'h1234_5678, 2'd2,  2,  1,  0, 32'h0,         1'b0, 8'h00};
      vecs[1] = '{"rd_s1_wait3",  1'b1, 1'b0, 14'h0044, 14'h0000, 32'h0,         2'd0,  6,  0,  4, 32'hCAFE_F00D, 1'b0, 8'h00};
      vecs[2] = '{"rw_s0",        1'b1, 1'b1, 14'h0020, 14'h0010, 32'hA5A5_0001, 2'd1,  4,  1,  1, 32'h0000_1111, 1'b0, 8'h00};
      vecs[3] = '{"rd_s2",        1'b1, 1'b0, 14'h01A0, 14'h0000, 32'h0,         2'd0,  3,  0,  1, 32'h2222_2222, 1'b0, 8'h00};
      vecs[4] = '{"rw_wr_wait",   1'b1, 1'b1, 14'h0080, 14'h0050, 32'h5A5A_0002, 2'd3,  7,  4,  1, 32'h2222_2222, 1'b0, 8'h00};
      vecs[5] = '{"wr_s1_wait3",  1'b0, 1'b1, 14'h0000, 14'h007F, 32'hFFFF_0000, 2'd0,  5,  4,  0, 32'h0,         1'b0, 8'h00};
      vecs[6] = '{"rd_timeout",   1'b1, 1'b0, 14'h00C4, 14'h0000, 32'h0,         2'd0, 18,  0, 16, 32'hDEAD_BEEF, 1'b1, 8'hC4};
      vecs[7] = '{"wr_timeout2",  1'b0, 1'b1, 14'h0000, 14'h00C8, 32'h0BAD_0BAD, 2'd2, 17, 16,  0, 32'h0,         1'b1, 8'hC4};

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // err_clr landing in the same cycle as a new timeout: the timeout wins.
      @(negedge clk);
      hb_wen = 1'b1; hb_waddr = 14'h00D0; hb_wdata = 32'h0000_00D0; hb_write_width = 2'd2;
      @(negedge clk);
      hb_wen = 1'b0;
      repeat (15) @(negedge clk);
      check("same_cyc lb_wen_at_limit", lb_wen, 1'b1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("same_cyc hb_ready", hb_ready, 1'b1);
      check("same_cyc err",      err,      1'b1);
      check("same_cyc err_addr", err_addr, 8'hD0);

      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("clr err",      err,      1'b0);
      check("clr err_addr", err_addr, 8'h00);

      run_vec(vecs[6]);

      // Asynchronous reset in the middle of a waited read.
      @(negedge clk);
      hb_ren = 1'b1; hb_raddr = 14'h0044;
      @(negedge clk);
      hb_ren = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst hb_ready", hb_ready, 1'b1);
      check("arst lb_ren",   lb_ren,   1'b0);
      check("arst lb_addr",  lb_addr,  8'h00);
      check("arst hb_rdata", hb_rdata, 32'h0);
      check("arst err",      err,      1'b0);
      check("arst err_addr", err_addr, 8'h00);
      check("arst lb_wdata", lb_wdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      rdata_hold = '0;
      rv_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (hb_rvalid) rv_cnt++;
      end
      check("arst no_rvalid", rv_cnt,   0);
      check("arst idle",      hb_ready, 1'b1);
      run_vec(vecs[1]);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
